// File: rtl/par_frame_tx.sv
// par_frame_tx: transmit side of the 4-bit parity link.
// Accepts a nibble over valid/ready, computes its parity bit, and serialises
// start, d0..d3, parity and stop onto tx. Each bit is held for CLKS_PER_BIT cycles.
module par_frame_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter bit ODD_PARITY   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       force_err,
  output logic       tx,
  output logic       par,
  output logic       busy,
  output logic       done
);

  // The cycle counter is always at least one bit wide, even when CLKS_PER_BIT is 1.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic [3:0]    sh;
  logic [1:0]    idx;
  logic [CW-1:0] cnt;

  // Only IDLE can take a new nibble. This includes the done cycle, so frames can run back to back.
  assign in_ready = (state == IDLE);

  // Frame sequencer. tx always holds the value of the bit currently on the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sh    <= 4'd0;
      idx   <= 2'd0;
      cnt   <= '0;
      tx    <= 1'b1;
      par   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh    <= in_data;
            par   <= (^in_data) ^ ODD_PARITY ^ force_err;
            state <= START;
            tx    <= 1'b0;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            idx   <= 2'd0;
            state <= DATA;
            tx    <= sh[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (idx == 2'd3) begin
              state <= PARITY;
              tx    <= par;
            end else begin
              idx <= idx + 2'd1;
              tx  <= sh[idx + 2'd1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= STOP;
            tx    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= IDLE;
            tx    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_par_frame_tx.sv
// Directed bench for par_frame_tx. Three instances are used:
//   instance 0: CLKS_PER_BIT=4, even parity
//   instance 1: CLKS_PER_BIT=4, odd parity
//   instance 2: CLKS_PER_BIT=1, even parity
module tb_par_frame_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] din [3];
  logic       vld [3];
  logic       fe  [3];
  logic       rdy [3];
  logic       txo [3];
  logic       paro[3];
  logic       bsy [3];
  logic       dne [3];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  par_frame_tx #(.CLKS_PER_BIT(4), .ODD_PARITY(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_data(din[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
    .force_err(fe[0]), .tx(txo[0]), .par(paro[0]), .busy(bsy[0]), .done(dne[0]));
  par_frame_tx #(.CLKS_PER_BIT(4), .ODD_PARITY(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_data(din[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
    .force_err(fe[1]), .tx(txo[1]), .par(paro[1]), .busy(bsy[1]), .done(dne[1]));
  par_frame_tx #(.CLKS_PER_BIT(1), .ODD_PARITY(1'b0)) dut2 (
    .clk(clk), .rst(rst), .in_data(din[2]), .in_valid(vld[2]), .in_ready(rdy[2]),
    .force_err(fe[2]), .tx(txo[2]), .par(paro[2]), .busy(bsy[2]), .done(dne[2]));

  // One frame record. slots[k] is the expected tx level in bit slot k:
  // slot 0 is the start bit, slots 1..4 are d0..d3, slot 5 is parity, slot 6 is stop.
  typedef struct {
    int         sel;
    int         cpb;
    logic [3:0] d;
    logic       f;
    logic       p;
    logic [6:0] slots;
    logic       rxchk;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic act, input logic exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_idle(input int sel, input string tag);
    chk({tag, " tx"}, txo[sel], 1'b1);
    chk({tag, " busy"}, bsy[sel], 1'b0);
    chk({tag, " in_ready"}, rdy[sel], 1'b1);
    chk({tag, " done"}, dne[sel], 1'b0);
  endtask

  // Apply the nibble at a negedge. The DUT accepts it on the next rising edge,
  // and in_valid stays high only if hold is set.
  task automatic accept(input int sel, input logic [3:0] d, input logic f, input bit hold);
    @(negedge clk);
    din[sel] = d;
    fe[sel]  = f;
    vld[sel] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) vld[sel] = 1'b0;
  endtask

  // Call this just after the accept edge. It checks every cycle of the frame and
  // then the done cycle. When cycle number chg_cycle is reached, in_data is
  // replaced by chg_val. got[k] returns the level sampled in the middle of slot k.
  task automatic check_frame(input int sel, input int cpb, input logic [6:0] slots,
                             input logic ep, input int chg_cycle,
                             input logic [3:0] chg_val, output logic [6:0] got);
    int n;
    n   = 0;
    got = '0;
    for (int k = 0; k < 7; k++) begin
      for (int j = 0; j < cpb; j++) begin
        @(negedge clk);
        n++;
        if (n == chg_cycle) din[sel] = chg_val;
        if (n == 1) chk("par latched", paro[sel], ep);
        chk($sformatf("tx slot%0d", k), txo[sel], slots[k]);
        chk("busy in frame", bsy[sel], 1'b1);
        chk("in_ready in frame", rdy[sel], 1'b0);
        chk("done in frame", dne[sel], 1'b0);
        if (j == cpb / 2) got[k] = txo[sel];
      end
    end
    @(negedge clk);
    chk("done pulse", dne[sel], 1'b1);
    chk("busy at done", bsy[sel], 1'b0);
    chk("tx at done", txo[sel], 1'b1);
    chk("in_ready at done", rdy[sel], 1'b1);
    chk("par held", paro[sel], ep);
  endtask

  initial begin
    logic [6:0] got;

    for (int i = 0; i < 3; i++) begin
      din[i] = 4'd0;
      vld[i] = 1'b0;
      fe[i]  = 1'b0;
    end

    vecs[0] = '{sel: 0, cpb: 4, d: 4'b1011, f: 1'b0, p: 1'b1, slots: 7'b1110110, rxchk: 1'b0};
    vecs[1] = '{sel: 0, cpb: 4, d: 4'b0110, f: 1'b1, p: 1'b1, slots: 7'b1101100, rxchk: 1'b1};
    vecs[2] = '{sel: 0, cpb: 4, d: 4'b0000, f: 1'b0, p: 1'b0, slots: 7'b1000000, rxchk: 1'b0};
    vecs[3] = '{sel: 1, cpb: 4, d: 4'b0000, f: 1'b0, p: 1'b1, slots: 7'b1100000, rxchk: 1'b1};
    vecs[4] = '{sel: 1, cpb: 4, d: 4'b0111, f: 1'b1, p: 1'b1, slots: 7'b1101110, rxchk: 1'b0};
    vecs[5] = '{sel: 2, cpb: 1, d: 4'b0101, f: 1'b0, p: 1'b0, slots: 7'b1001010, rxchk: 1'b0};

    // Hold reset for 3 cycles, then leave the inputs idle for 20 cycles.
    repeat (3) @(negedge clk);
    chk("reset tx", txo[0], 1'b1);
    chk("reset par", paro[0], 1'b0);
    chk("reset busy", bsy[0], 1'b0);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) chk_idle(s, "idle");
    end
    $display("reset/idle: 20 idle cycles checked");

    // Frames from the table.
    for (int v = 0; v < 6; v++) begin
      accept(vecs[v].sel, vecs[v].d, vecs[v].f, 1'b0);
      check_frame(vecs[v].sel, vecs[v].cpb, vecs[v].slots, vecs[v].p, 0, 4'd0, got);
      chk("rx xor check", ^got[5:1], vecs[v].rxchk);
      $display("frame dut%0d data=%b force_err=%b par=%b line=%b", vecs[v].sel,
               vecs[v].d, vecs[v].f, paro[vecs[v].sel], got);
      @(negedge clk);
      chk_idle(vecs[v].sel, "post frame");
    end

    // Back to back. in_valid stays high; in_data changes to 1111 during d1 of the first frame.
    accept(0, 4'b0001, 1'b0, 1'b1);
    check_frame(0, 4, 7'b1100010, 1'b1, 9, 4'b1111, got);
    $display("b2b frame1 data=0001 line=%b", got);
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    check_frame(0, 4, 7'b1011110, 1'b0, 0, 4'd0, got);
    $display("b2b frame2 data=1111 line=%b", got);
    @(negedge clk);
    chk_idle(0, "after b2b");

    // Assert reset asynchronously while d2 is on the line (slot 3 has tx=0 for 1011).
    accept(0, 4'b1011, 1'b0, 1'b0);
    repeat (3 * 4 + 1) @(negedge clk);
    chk("pre-reset tx d2", txo[0], 1'b0);
    chk("pre-reset busy", bsy[0], 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("async rst tx", txo[0], 1'b1);
    chk("async rst busy", bsy[0], 1'b0);
    chk("async rst in_ready", rdy[0], 1'b1);
    chk("async rst par", paro[0], 1'b0);
    $display("async reset mid-frame applied");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_idle(0, "post reset");
    accept(0, 4'b1000, 1'b0, 1'b0);
    check_frame(0, 4, 7'b1110000, 1'b1, 0, 4'd0, got);
    $display("frame after reset data=1000 line=%b", got);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
